// File: rtl/key_capture_4_if.sv
// Request/acknowledge bundle between the key-capture front end and its consumer.
// The master side drives the raw request lines and ack; the slave side returns
// the held one-hot code, its valid flag and the sticky overflow flag.
interface key_capture_4_if;
   logic d3;
   logic d2;
   logic d1;
   logic d0;
   logic ack;
   logic q3;
   logic q2;
   logic q1;
   logic q0;
   logic valid;
   logic ovf;

   modport master (
      output d3, d2, d1, d0, ack,
      input  q3, q2, q1, q0, valid, ovf
   );

   modport slave (
      input  d3, d2, d1, d0, ack,
      output q3, q2, q1, q0, valid, ovf
   );
endinterface

// File: rtl/key_capture_4.sv
// Key capture front end for the 4-to-2 priority encoder.
// Four raw request lines are synchronised, debounced and edge-detected; one
// press is latched as a one-hot code and held until the consumer acknowledges.
// Presses that cannot be latched set a sticky overflow flag.
module key_capture_4 #(
   parameter int unsigned DB_CYCLES = 4,
   parameter int unsigned CW        = 8
) (
   input logic            clk,
   input logic            rst,
   key_capture_4_if.slave bus
);

   // Terminal count of the debounce counter: the level flips on the
   // DB_CYCLES-th consecutive cycle that differs from it.
   localparam logic [CW-1:0] CntLast = CW'(DB_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   logic [3:0]    raw;
   logic [3:0]    s1_q;
   logic [3:0]    s2_q;
   logic [3:0]    st_q;
   logic [3:0]    std_q;
   logic [CW-1:0] cnt_q [4];
   logic [3:0]    rise;
   logic [3:0]    pick;
   logic [3:0]    dropped;
   state_e        state_q;
   logic [3:0]    q_q;
   logic          valid_q;
   logic          ovf_q;

   assign raw = {bus.d3, bus.d2, bus.d1, bus.d0};

   // Two-flop synchroniser per line; the raw lines are asynchronous to clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Per-line debounce: the stable level follows s2 only after DB_CYCLES
   // consecutive differing cycles; any return to the level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s2_q[i] == st_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               st_q[i]  <= s2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // One-cycle delayed copy of the debounced levels for press detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         std_q <= '0;
      end else begin
         std_q <= st_q;
      end
   end

   // Press events only; releases are ignored.
   assign rise = st_q & ~std_q;

   // Highest-index rising line wins; every other rising line is dropped.
   always_comb begin
      pick = 4'b0000;
      if (rise[3]) begin
         pick = 4'b1000;
      end else if (rise[2]) begin
         pick = 4'b0100;
      end else if (rise[1]) begin
         pick = 4'b0010;
      end else if (rise[0]) begin
         pick = 4'b0001;
      end
   end

   assign dropped = rise & ~pick;

   // Capture/hold FSM with registered code, valid and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         q_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               // ack has no effect here
               if (|rise) begin
                  state_q <= StHold;
                  q_q     <= pick;
                  valid_q <= 1'b1;
                  if (|dropped) begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            StHold: begin
               if (!bus.ack) begin
                  if (|rise) begin
                     ovf_q <= 1'b1;
                  end
               end else if (|rise) begin
                  // Consumer took the old code in the same cycle a new press
                  // arrived: reload without dropping out of HOLD. A fresh drop
                  // overrides the ack clear.
                  q_q   <= pick;
                  ovf_q <= |dropped;
               end else begin
                  state_q <= StIdle;
                  q_q     <= '0;
                  valid_q <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               q_q     <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q3    = q_q[3];
   assign bus.q2    = q_q[2];
   assign bus.q1    = q_q[1];
   assign bus.q0    = q_q[0];
   assign bus.valid = valid_q;
   assign bus.ovf   = ovf_q;

`ifndef SYNTHESIS
   // Held code is zero or one-hot, and one-hot exactly when valid.
   a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(q_q));
   a_valid_q : assert property (@(posedge clk) disable iff (rst) valid_q == (q_q != 4'b0000));
   a_valid_st : assert property (@(posedge clk) disable iff (rst)
                                 valid_q == (state_q == StHold));
`endif

endmodule

// File: tb/tb_key_capture_4.sv
// Bench for key_capture_4: directed scenarios plus a randomized run checked
// against a cycle-level reference model built from the raw-sample history.
module tb_key_capture_4;

   localparam int unsigned DB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   key_capture_4_if bus ();

   key_capture_4 #(
      .DB_CYCLES(DB),
      .CW       (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model state.
   // hist[i][j]: raw sample of line i taken j+1 edges before the current one.
   bit       hist [4][8];
   bit       lvl  [4];
   bit       prev [4];
   bit [3:0] mq   = '0;
   bit       mv   = 1'b0;
   bit       movf = 1'b0;

   function automatic logic [3:0] dut_q();
      return {bus.q3, bus.q2, bus.q1, bus.q0};
   endfunction

   // Advance the model by one rising edge using the inputs present at that edge.
   function automatic void model_edge();
      bit [3:0] raw;
      bit [3:0] rise;
      bit [3:0] one;
      int       hi;
      bit       flip;
      raw = {bus.d3, bus.d2, bus.d1, bus.d0};
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) hist[i][j] = 1'b0;
            lvl[i]  = 1'b0;
            prev[i] = 1'b0;
         end
         mq   = '0;
         mv   = 1'b0;
         movf = 1'b0;
         return;
      end
      for (int i = 0; i < 4; i++) rise[i] = lvl[i] & ~prev[i];
      hi = -1;
      for (int i = 3; i >= 0; i--) if (rise[i] && hi < 0) hi = i;
      one = (hi >= 0) ? 4'(1 << hi) : 4'b0000;
      if (!mv) begin
         if (hi >= 0) begin
            mq = one;
            mv = 1'b1;
            if (rise != one) movf = 1'b1;
         end
      end else if (!bus.ack) begin
         if (rise != 4'b0000) movf = 1'b1;
      end else if (hi >= 0) begin
         mq   = one;
         movf = (rise != one);
      end else begin
         mq   = '0;
         mv   = 1'b0;
         movf = 1'b0;
      end
      // Level flips once the last DB synchronised samples (raw taken 2..DB+1
      // edges ago) all disagree with it.
      for (int i = 0; i < 4; i++) begin
         flip = 1'b1;
         for (int j = 1; j <= int'(DB); j++) if (hist[i][j] == lvl[i]) flip = 1'b0;
         prev[i] = lvl[i];
         if (flip) lvl[i] = ~lvl[i];
         for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
         hist[i][0] = raw[i];
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_d(input logic [3:0] v);
      {bus.d3, bus.d2, bus.d1, bus.d0} = v;
   endtask

   task automatic ack_pulse();
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (bus.valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_d(4'b0000);
      bus.ack = 1'b0;
      repeat (2) tick();
      tests++;
      if ({dut_q(), bus.valid, bus.ovf} !== 6'b0) begin
         fails++;
         $display("FAIL reset_state: got q=%b valid=%b ovf=%b, want 0000 0 0",
                  dut_q(), bus.valid, bus.ovf);
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         tests++;
         if ({dut_q(), bus.valid, bus.ovf} !== 6'b0) begin
            fails++;
            $display("FAIL idle_quiet cyc %0d: got q=%b valid=%b ovf=%b, want 0000 0 0",
                     c, dut_q(), bus.valid, bus.ovf);
         end
      end
   endtask

   task automatic test_single_press();
      int n;
      set_d(4'b0010);
      wait_valid(20, n);
      tests++;
      if (n != 7) begin
         fails++;
         $display("FAIL press_latency: got %0d edges, want 7", n);
      end
      tests++;
      if (dut_q() !== 4'b0010 || bus.ovf !== 1'b0) begin
         fails++;
         $display("FAIL press_code: got q=%b ovf=%b, want 0010 0", dut_q(), bus.ovf);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         tests++;
         if (dut_q() !== 4'b0010 || bus.valid !== 1'b1) begin
            fails++;
            $display("FAIL press_hold cyc %0d: got q=%b valid=%b, want 0010 1",
                     c, dut_q(), bus.valid);
         end
      end
      ack_pulse();
      tests++;
      if (dut_q() !== 4'b0000 || bus.valid !== 1'b0) begin
         fails++;
         $display("FAIL press_ack: got q=%b valid=%b, want 0000 0", dut_q(), bus.valid);
      end
      set_d(4'b0000);
      for (int c = 0; c < 12; c++) begin
         tick();
         tests++;
         if (bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL release_no_event cyc %0d: got valid=%b, want 0", c, bus.valid);
         end
      end
   endtask

   task automatic test_glitch();
      int n;
      set_d(4'b0100);
      repeat (3) tick();
      set_d(4'b0000);
      for (int c = 0; c < 15; c++) begin
         tick();
         tests++;
         if (bus.valid !== 1'b0 || bus.ovf !== 1'b0) begin
            fails++;
            $display("FAIL glitch_reject cyc %0d: got valid=%b ovf=%b, want 0 0",
                     c, bus.valid, bus.ovf);
         end
      end
      set_d(4'b0100);
      repeat (4) tick();
      set_d(4'b0000);
      wait_valid(12, n);
      tests++;
      if (dut_q() !== 4'b0100 || bus.valid !== 1'b1) begin
         fails++;
         $display("FAIL glitch_accept: got q=%b valid=%b, want 0100 1", dut_q(), bus.valid);
      end
      ack_pulse();
      repeat (10) tick();
   endtask

   task automatic test_simultaneous();
      int n;
      set_d(4'b1001);
      wait_valid(20, n);
      tests++;
      if (dut_q() !== 4'b1000 || bus.valid !== 1'b1 || bus.ovf !== 1'b1) begin
         fails++;
         $display("FAIL simul_capture: got q=%b valid=%b ovf=%b, want 1000 1 1",
                  dut_q(), bus.valid, bus.ovf);
      end
      ack_pulse();
      tests++;
      if ({dut_q(), bus.valid, bus.ovf} !== 6'b0) begin
         fails++;
         $display("FAIL simul_ack: got q=%b valid=%b ovf=%b, want 0000 0 0",
                  dut_q(), bus.valid, bus.ovf);
      end
      set_d(4'b0000);
      repeat (10) tick();
   endtask

   task automatic test_back_to_back();
      int n;
      set_d(4'b0001);
      wait_valid(20, n);
      set_d(4'b0101);
      repeat (10) tick();
      tests++;
      if (dut_q() !== 4'b0001 || bus.valid !== 1'b1 || bus.ovf !== 1'b1) begin
         fails++;
         $display("FAIL hold_drop: got q=%b valid=%b ovf=%b, want 0001 1 1",
                  dut_q(), bus.valid, bus.ovf);
      end
      ack_pulse();
      tests++;
      if ({dut_q(), bus.valid, bus.ovf} !== 6'b0) begin
         fails++;
         $display("FAIL hold_drop_ack: got q=%b valid=%b ovf=%b, want 0000 0 0",
                  dut_q(), bus.valid, bus.ovf);
      end
      set_d(4'b0000);
      repeat (10) tick();
      set_d(4'b0001);
      wait_valid(20, n);
      set_d(4'b0101);
      repeat (6) tick();
      ack_pulse();
      tests++;
      if (dut_q() !== 4'b0100 || bus.valid !== 1'b1 || bus.ovf !== 1'b0) begin
         fails++;
         $display("FAIL ack_reload: got q=%b valid=%b ovf=%b, want 0100 1 0",
                  dut_q(), bus.valid, bus.ovf);
      end
      ack_pulse();
      set_d(4'b0000);
      repeat (10) tick();
   endtask

   task automatic test_reset_mid_hold();
      int n;
      set_d(4'b0010);
      wait_valid(20, n);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({dut_q(), bus.valid, bus.ovf} !== 6'b0) begin
         fails++;
         $display("FAIL mid_hold_reset: got q=%b valid=%b ovf=%b, want 0000 0 0",
                  dut_q(), bus.valid, bus.ovf);
      end
      wait_valid(20, n);
      tests++;
      if (n != int'(DB) + 3 || dut_q() !== 4'b0010) begin
         fails++;
         $display("FAIL recapture: got %0d edges q=%b, want %0d edges q=0010",
                  n, dut_q(), DB + 3);
      end
      ack_pulse();
      set_d(4'b0000);
      repeat (10) tick();
   endtask

   task automatic test_random();
      logic [3:0] d;
      d = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 4) == 0) d[i] = ~d[i];
         set_d(d);
         bus.ack = ($urandom_range(0, 3) == 0);
         rst     = ($urandom_range(0, 299) == 0);
         tick();
         tests++;
         if (dut_q() !== mq || bus.valid !== mv || bus.ovf !== movf) begin
            fails++;
            $display("FAIL random cyc %0d: got q=%b valid=%b ovf=%b, want %b %b %b",
                     c, dut_q(), bus.valid, bus.ovf, mq, mv, movf);
         end
      end
      rst     = 1'b0;
      bus.ack = 1'b0;
   endtask

   initial begin
      set_d(4'b0000);
      bus.ack = 1'b0;
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule

// File: doc/key_capture_4.md
Name: key_capture_4

Overview:
- Upstream front end for the 4-to-2 priority encoder stage.
- Synchronises and debounces four raw push-button/request lines, then detects press (rising) events.
- Latches one captured press as a one-hot code on q3..q0 and holds it until the consumer acknowledges.
- q3..q0 drive the encoder's d3..d0 directly; valid marks when the encoded value is meaningful, because an all-zero input encodes to the same 00 as d0.

Parameters:
- DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (1 to 2^CW).
- CW, 8, width of each per-line debounce counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- d3  input  1  raw request line 3; highest priority; asynchronous to clk.
- d2  input  1  raw request line 2.
- d1  input  1  raw request line 1.
- d0  input  1  raw request line 0; lowest priority.
- ack  input  1  consumer has taken the held code; single-cycle pulse or level.
- q3  output  1  held one-hot bit 3.
- q2  output  1  held one-hot bit 2.
- q1  output  1  held one-hot bit 1.
- q0  output  1  held one-hot bit 0.
- valid  output  1  high while a captured code is held (state HOLD).
- ovf  output  1  sticky flag: at least one press event was dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears all sync flops, debounced levels, delayed levels and counters to 0.
  - Outputs: q3..q0=0000, valid=0, ovf=0, state=IDLE.
  - Applies mid-HOLD as well; the held code is lost and no event is reported.
  - A line held high through reset debounces to 1 after release from reset and produces a press event.
- Per-line synchroniser: 2 flops, s1 then s2.
- Per-line debounce (stable level st, counter cnt):
  - If s2==st: cnt<=0.
  - Else if cnt==DB_CYCLES-1: st<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any return of s2 to st before the count completes restarts the count, so glitches shorter than DB_CYCLES cycles are rejected.
- Press event: rise_i = st_i & ~std_i, where std_i is st_i delayed by one register. Releases (falling edges) generate no event.
- Latency: raw line high before edge k and held:
  - s1=1 at edge k, s2=1 at edge k+1.
  - st=1 at edge k+1+DB_CYCLES.
  - Captured into q/valid at edge k+2+DB_CYCLES (k+6 with default DB_CYCLES=4).
- FSM, 2 states:
  - IDLE: outputs 0000, valid=0. If any rise_i, load the one-hot of the highest-index rising line and go to HOLD. Every other line rising in the same cycle is dropped and sets ovf.
  - HOLD: q holds, valid=1.
    - ack=0: any rise is dropped and sets ovf.
    - ack=1 with no rise: clear q to 0000 and go to IDLE.
    - ack=1 with a rise in the same cycle: load the new highest-priority one-hot and stay in HOLD (valid stays 1). Lower rising lines are dropped and set ovf.
- ovf clearing: cleared by ack; a set in the same cycle as the ack wins, so ovf reads 1.
- ack while in IDLE has no effect.
- Invariant: q3..q0 is always 0000 or exactly one-hot, and is one-hot iff valid=1.
- All outputs are registered; there is no combinational path from d* or ack to any output.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all d=0 for 20 cycles -> q=0000, valid=0, ovf=0 throughout.
- Single press, DB_CYCLES=4: d1 rises before edge k and is held -> q=0010, valid=1 first seen after edge k+6; held for 10 cycles with ack=0; ack pulse -> q=0000, valid=0 one edge later; d1 release produces no new event.
- Glitch rejection: d2 high for 3 cycles then low -> no capture and ovf=0. d2 high for 4 cycles -> captured as q=0100.
- Simultaneous press in IDLE: d3 and d0 rise on the same edge -> q=1000, valid=1, ovf=1. After ack: q=0000, valid=0, ovf=0.
- Press while holding: hold q=0001, then d2 pressed with ack=0 -> q stays 0001, ovf=1. Separately, d2's rise coinciding with an ack pulse -> q=0100, valid stays 1.
- Reset mid-HOLD: q=0010, valid=1, rst pulsed for 1 cycle -> next edge q=0000, valid=0, ovf=0. d1 still held high re-captures q=0010 after DB_CYCLES+3 edges.
